l1_cache_dm: RTL and testbench
==============================

# l1_cache_dm

Direct-mapped, write-back, write-allocate L1 data cache of 256 bytes organised as 16 lines of 16 bytes. It sits between a single-issue CPU port (32-bit word accesses) and a line-granular main-memory port. Misses are serviced by a whole-line refill, preceded by a writeback when the victim line is dirty. A single FSM controls the block, with one outstanding request at a time.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, CPU word width
- CACHE_BYTES, 256, total capacity
- LINE_BYTES, 16, line size; LINE_COUNT = CACHE_BYTES/LINE_BYTES = 16

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req_valid  in  1  one-cycle request strobe, sampled only in IDLE
- cpu_req_rw  in  1  0 = read, 1 = write
- cpu_req_addr  in  32  byte address; bits [1:0] ignored
- cpu_req_wdata  in  32  write word
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_resp_rdata  out  32  read word; for a write, echoes the written word
- mem_req_valid  out  1  one-cycle memory request strobe
- mem_req_rw  out  1  0 = line read (refill), 1 = line write (writeback)
- mem_req_addr  out  32  line-aligned address, bits [3:0] = 0
- mem_req_wdata  out  128  writeback line; byte b at bits [8b+7:8b]
- mem_resp_valid  in  1  memory completion pulse
- mem_resp_rdata  in  128  refill line, same byte order

## Operation
- Address fields: offset [3:0], word select [3:2], index [7:4], tag [31:8].
- Per-line storage: valid, dirty, 24-bit tag, 128-bit data.
- Hit condition: valid[index] && tag[index] == tag field. This is exposed as an internal signal `hit`, which is meaningful in LOOKUP.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
  - IDLE: when cpu_req_valid = 1, latch rw, addr and wdata, then go to LOOKUP.
  - LOOKUP lasts exactly one cycle per access.
    - Hit, read: select the word and go to RESPOND.
    - Hit, write: write the selected word, set dirty, go to RESPOND.
    - Miss with a dirty victim: go to WRITEBACK.
    - Miss otherwise: go to REFILL.
  - WRITEBACK: issue mem_req rw = 1 with addr = {old tag, index, 4'h0} and wdata = the victim line. Wait for mem_resp_valid, then go to REFILL.
  - REFILL: issue mem_req rw = 0 with addr = {new tag, index, 4'h0}. On mem_resp_valid:
    - install the line with valid = 1 and the new tag;
    - for a write, merge cpu_req_wdata into the addressed word and set dirty = 1;
    - for a read, set dirty = 0 and capture the addressed word;
    - go to RESPOND.
  - RESPOND: cpu_resp_valid = 1 for one cycle, then go to IDLE.
- After a refill the FSM never returns to LOOKUP. Each access therefore passes through LOOKUP exactly once.
- cpu_req_valid is ignored in every state except IDLE. Requests raised while busy are dropped.
- mem_resp_valid is ignored outside WRITEBACK and REFILL.

## Timing
- Reset: state = IDLE; all valid and dirty bits = 0. All outputs are 0: cpu_resp_valid, cpu_resp_rdata, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata. Tag and data arrays need not be cleared.
- Reset asserted mid-operation aborts the access immediately. No response is issued and the cache returns to the empty state.
- mem_req_valid is registered and high only during the first cycle spent in WRITEBACK or REFILL. mem_req_rw, mem_req_addr and mem_req_wdata are held stable for the whole state.
- Memory may respond in any later cycle, minimum one cycle after the strobe. The FSM waits indefinitely.
- Latency, counted from the cycle in which the request is sampled (cycle 0):
  - Hit: LOOKUP in cycle 1, cpu_resp_valid in cycle 2.
  - Clean miss with 1-cycle memory: LOOKUP in cycle 1, REFILL in cycles 2–3, response in cycle 4.
  - Dirty miss: two additional cycles, for response in cycle 6.
- cpu_resp_rdata is valid while cpu_resp_valid = 1 and holds its value until the next response.

## Configuration
- L1_PERF_CNT_EN defined: the block contains three internal 32-bit counters, reset to 0 and wrapping on overflow:
  - hit_count, incremented in LOOKUP when hit;
  - miss_count, incremented on the REFILL completion cycle;
  - wb_count, incremented on the WRITEBACK completion cycle.
- L1_PERF_CNT_EN undefined: the counters are absent. Ports and functional behaviour are identical either way.

## Test plan
Memory is initialised with byte[a] = a[7:0] and responds one cycle after each strobe.
- Cold read 0x000 -> one refill at 0x000; cpu_resp_rdata = 0x03020100; no writeback.
- Write 0x010 with 0x00000065, then read 0x010 -> the write is a refill plus merge; the read is a hit returning 0x00000065, with no memory request.
- Write 0x000 with 0x00000001, then read 0x100 (same index, tag 1):
  - writeback at 0x000 carrying bytes 01 00 00 00 04 05 … 0F;
  - then refill at 0x100;
  - rdata = 0x03020100.
- Read 0x000 again -> miss; the refill returns the written-back data 0x00000001. The victim at 0x100 is clean, so there is no writeback.
- Fill all 16 lines with writes, then read all 16 -> 16 hits, 0 memory requests, each response exactly 2 cycles after its request.
- Assert rst_n low during a REFILL wait -> outputs go to 0 immediately. A subsequent read of the same address misses.

Source files
------------

// File: rtl/l1_cache_dm.sv
// l1_cache_dm: direct-mapped, write-back, write-allocate L1 data cache.
//   256 bytes as 16 lines of 16 bytes; one outstanding CPU request at a time.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cpu_req_*         request strobe, sampled only while idle (rw: 1 = write)
//   cpu_resp_*        one-cycle completion pulse; rdata held until the next one
//   mem_req_*         line request; valid pulses on entry to WRITEBACK/REFILL,
//                     rw/addr/wdata held for the whole state
//   mem_resp_*        line completion pulse and refill data
//
// Optional build macro
//   L1_PERF_CNT_EN    adds internal hit/miss/writeback counters (32-bit, wrapping)
module l1_cache_dm #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CACHE_BYTES = 256,
  parameter int LINE_BYTES  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req_valid,
  input  logic                    cpu_req_rw,
  input  logic [ADDR_WIDTH-1:0]   cpu_req_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_req_wdata,
  output logic                    cpu_resp_valid,
  output logic [DATA_WIDTH-1:0]   cpu_resp_rdata,
  output logic                    mem_req_valid,
  output logic                    mem_req_rw,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [LINE_BYTES*8-1:0] mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0] mem_resp_rdata
);

  localparam int LINE_COUNT = CACHE_BYTES / LINE_BYTES;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int IDX_W      = $clog2(LINE_COUNT);
  localparam int TAG_W      = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int BOFF_W     = $clog2(DATA_WIDTH / 8);
  localparam int WSEL_W     = OFF_W - BOFF_W;
  localparam int BIT_W      = $clog2(LINE_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND
  } state_t;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q, req_d;

  logic [LINE_COUNT-1:0]             valid_q, valid_d;
  logic [LINE_COUNT-1:0]             dirty_q, dirty_d;
  logic [LINE_COUNT-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [LINE_COUNT-1:0][LINE_W-1:0] data_q, data_d;

  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  mreq_valid_q, mreq_valid_d;
  logic                  mreq_rw_q, mreq_rw_d;
  logic [ADDR_WIDTH-1:0] mreq_addr_q, mreq_addr_d;
  logic [LINE_W-1:0]     mreq_wdata_q, mreq_wdata_d;

  // Latched request fields.
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic [BIT_W-1:0]  wbit;
  logic              hit;

  assign idx  = req_q.addr[OFF_W +: IDX_W];
  assign tag  = req_q.addr[ADDR_WIDTH-1 -: TAG_W];
  assign wsel = req_q.addr[BOFF_W +: WSEL_W];
  assign wbit = {wsel, {(BIT_W-WSEL_W){1'b0}}};
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);

  // Byte-within-word bits never select anything: accesses are whole words.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_q.addr[BOFF_W-1:0];

  logic [LINE_W-1:0] hit_merge, refill_merge;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mreq_valid_d = 1'b0;
    mreq_rw_d    = mreq_rw_q;
    mreq_addr_d  = mreq_addr_q;
    mreq_wdata_d = mreq_wdata_q;

    hit_merge                        = data_q[idx];
    hit_merge[wbit +: DATA_WIDTH]    = req_q.wdata;
    refill_merge                     = mem_resp_rdata;
    refill_merge[wbit +: DATA_WIDTH] = req_q.wdata;

    case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          req_d   = '{rw: cpu_req_rw, addr: cpu_req_addr, wdata: cpu_req_wdata};
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          if (req_q.rw) begin
            data_d[idx]  = hit_merge;
            dirty_d[idx] = 1'b1;
            resp_rdata_d = req_q.wdata;
          end else begin
            resp_rdata_d = data_q[idx][wbit +: DATA_WIDTH];
          end
          resp_valid_d = 1'b1;
          state_d      = S_RESPOND;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          // Victim address is rebuilt from the stored tag, not the request.
          mreq_valid_d = 1'b1;
          mreq_rw_d    = 1'b1;
          mreq_addr_d  = {tag_q[idx], idx, {OFF_W{1'b0}}};
          mreq_wdata_d = data_q[idx];
          state_d      = S_WRITEBACK;
        end else begin
          mreq_valid_d = 1'b1;
          mreq_rw_d    = 1'b0;
          mreq_addr_d  = {tag, idx, {OFF_W{1'b0}}};
          state_d      = S_REFILL;
        end
      end
      S_WRITEBACK: begin
        if (mem_resp_valid) begin
          mreq_valid_d = 1'b1;
          mreq_rw_d    = 1'b0;
          mreq_addr_d  = {tag, idx, {OFF_W{1'b0}}};
          state_d      = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_resp_valid) begin
          valid_d[idx] = 1'b1;
          tag_d[idx]   = tag;
          if (req_q.rw) begin
            data_d[idx]  = refill_merge;
            dirty_d[idx] = 1'b1;
            resp_rdata_d = req_q.wdata;
          end else begin
            data_d[idx]  = mem_resp_rdata;
            dirty_d[idx] = 1'b0;
            resp_rdata_d = mem_resp_rdata[wbit +: DATA_WIDTH];
          end
          resp_valid_d = 1'b1;
          state_d      = S_RESPOND;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mreq_valid_q <= 1'b0;
      mreq_rw_q    <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mreq_valid_q <= mreq_valid_d;
      mreq_rw_q    <= mreq_rw_d;
      mreq_addr_q  <= mreq_addr_d;
      mreq_wdata_q <= mreq_wdata_d;
    end
  end

  // Tag/data contents are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_rdata = resp_rdata_q;
  assign mem_req_valid  = mreq_valid_q;
  assign mem_req_rw     = mreq_rw_q;
  assign mem_req_addr   = mreq_addr_q;
  assign mem_req_wdata  = mreq_wdata_q;

`ifdef L1_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic [31:0] wb_count_q, wb_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wb_count_d   = wb_count_q;
    if (state_q == S_LOOKUP && hit)              hit_count_d  = hit_count_q + 32'd1;
    if (state_q == S_REFILL && mem_resp_valid)    miss_count_d = miss_count_q + 32'd1;
    if (state_q == S_WRITEBACK && mem_resp_valid) wb_count_d   = wb_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end
`else
  // Counters absent; the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_l1_cache_dm.sv
module tb_l1_cache_dm;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req_valid, cpu_req_rw;
  logic [31:0]  cpu_req_addr, cpu_req_wdata;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic         mem_req_valid, mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rdata;

  l1_cache_dm dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- main memory model ----------------
  typedef struct {
    bit           rw;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mreq_t;

  mreq_t        memlog[$];
  logic [127:0] mem_line[int unsigned];
  bit           pend, mem_stall;
  logic [31:0]  pend_addr;

  // byte[a] = a[7:0] unless the line has been written back.
  function automatic logic [127:0] backing(logic [31:0] la);
    logic [127:0] ln;
    if (mem_line.exists(la)) return mem_line[la];
    for (int b = 0; b < 16; b++) ln[8*b +: 8] = la[7:0] + 8'(b);
    return ln;
  endfunction

  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (pend && !mem_stall) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = backing(pend_addr);
        pend = 1'b0;
      end
      if (rst_n && mem_req_valid) begin
        memlog.push_back('{mem_req_rw, mem_req_addr, mem_req_wdata});
        if (mem_req_rw) mem_line[mem_req_addr] = mem_req_wdata;
        pend      = 1'b1;
        pend_addr = mem_req_addr;
      end
    end
  end

  // ---------------- reference model ----------------
  // CPU view: last written word, else whatever main memory holds.
  logic [31:0] gold[int unsigned];
  bit          r_valid[16];
  bit          r_dirty[16];
  logic [31:0] r_line[16];

  function automatic logic [31:0] gword(logic [31:0] a);
    logic [31:0]  wa;
    logic [127:0] ln;
    wa = a & ~32'h3;
    if (gold.exists(wa)) return gold[wa];
    ln = backing(a & ~32'hF);
    return ln[32*int'(wa[3:2]) +: 32];
  endfunction

  // Hit costs 2 cycles; each line transfer with 1-cycle memory costs 2 more.
  function automatic void model_step(bit rw, logic [31:0] a, output int elat, output int ereq);
    int          idx;
    logic [31:0] la;
    idx = int'(a[7:4]);
    la  = a & ~32'hF;
    if (r_valid[idx] && r_line[idx] == la) begin
      ereq = 0;
      if (rw) r_dirty[idx] = 1'b1;
    end else begin
      ereq = (r_valid[idx] && r_dirty[idx]) ? 2 : 1;
      r_valid[idx] = 1'b1;
      r_line[idx]  = la;
      r_dirty[idx] = rw;
    end
    elat = 2 + 2 * ereq;
    if (rw) gold[a & ~32'h3] = '0;
  endfunction

  function automatic void model_reset();
    foreach (r_valid[i]) begin r_valid[i] = 1'b0; r_dirty[i] = 1'b0; end
    gold.delete();
  endfunction

  // ---------------- CPU driver ----------------
  task automatic access(input bit rw, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output int nreq);
    int c0, n0;
    bit seen;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = a; cpu_req_wdata = wd;
    c0 = cyc; n0 = memlog.size();
    @(negedge clk);
    cpu_req_valid = 1'b0;
    seen = 1'b0; rd = 'x; lat = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (cpu_resp_valid) begin
        seen = 1'b1; rd = cpu_resp_rdata; lat = cyc - c0;
      end else @(negedge clk);
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL resp_timeout: no response for addr %0h", a);
    end
    nreq = memlog.size() - n0;
  endtask

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_req;
    logic [31:0] exp_a0;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd, a, wd, exp_rd;
    int lat, nreq, elat, ereq;
    bit seen;

    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_rw = 1'b0;
    cpu_req_addr = '0; cpu_req_wdata = '0;
    pend = 1'b0; mem_stall = 1'b0; pend_addr = '0;
    model_reset();

    // Directed sequence with hand-computed expectations.
    tbl.push_back('{0, 32'h000, 32'h0,  32'h03020100, 4, 1, 32'h000});
    tbl.push_back('{1, 32'h010, 32'h65, 32'h00000065, 4, 1, 32'h010});
    tbl.push_back('{0, 32'h010, 32'h0,  32'h00000065, 2, 0, 32'h0});
    tbl.push_back('{1, 32'h000, 32'h1,  32'h00000001, 2, 0, 32'h0});
    tbl.push_back('{0, 32'h100, 32'h0,  32'h03020100, 6, 2, 32'h000});
    tbl.push_back('{0, 32'h000, 32'h0,  32'h00000001, 4, 1, 32'h000});
    // Fill every line: index 0 victim is clean, index 1 still holds dirty 0x010.
    for (int i = 0; i < 16; i++)
      tbl.push_back('{1, 32'h200 + 32'(16*i), 32'hA000_0000 + 32'(i), 32'hA000_0000 + 32'(i),
                      (i == 1) ? 6 : 4, (i == 1) ? 2 : 1,
                      (i == 1) ? 32'h010 : 32'h200 + 32'(16*i)});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{0, 32'h200 + 32'(16*i), 32'h0, 32'hA000_0000 + 32'(i), 2, 0, 32'h0});

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_resp_valid", 128'(cpu_resp_valid), 128'(0));
    chk("rst_cpu_resp_rdata", 128'(cpu_resp_rdata), 128'(0));
    chk("rst_mem_req_valid",  128'(mem_req_valid),  128'(0));
    chk("rst_mem_req_rw",     128'(mem_req_rw),     128'(0));
    chk("rst_mem_req_addr",   128'(mem_req_addr),   128'(0));
    chk("rst_mem_req_wdata",  mem_req_wdata,        128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      access(tbl[i].rw, tbl[i].addr, tbl[i].wdata, rd, lat, nreq);
      model_step(tbl[i].rw, tbl[i].addr, elat, ereq);
      if (tbl[i].rw) gold[tbl[i].addr & ~32'h3] = tbl[i].wdata;
      chk($sformatf("tbl%0d_rdata", i), 128'(rd), 128'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_latency", i), 128'(lat), 128'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_memreqs", i), 128'(nreq), 128'(tbl[i].exp_req));
      if (tbl[i].exp_req > 0 && nreq > 0)
        chk($sformatf("tbl%0d_memaddr", i), 128'(memlog[memlog.size()-nreq].addr),
            128'(tbl[i].exp_a0));
    end

    // The first writeback carries line 0 with word 0 overwritten by 1.
    seen = 1'b0;
    foreach (memlog[k]) if (!seen && memlog[k].rw) begin
      seen = 1'b1;
      chk("wb0_addr",  128'(memlog[k].addr), 128'(0));
      chk("wb0_wdata", memlog[k].wdata, 128'h0F0E0D0C_0B0A0908_07060504_00000001);
    end
    chk("wb0_present", 128'(seen), 128'(1));

    // Reset while a refill is outstanding.
    mem_stall = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h300; cpu_req_wdata = '0;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_req_valid) seen = 1'b1; else @(negedge clk);
    end
    chk("midrst_refill_issued", 128'(seen), 128'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cpu_resp_valid", 128'(cpu_resp_valid), 128'(0));
    chk("midrst_cpu_resp_rdata", 128'(cpu_resp_rdata), 128'(0));
    chk("midrst_mem_req_valid",  128'(mem_req_valid),  128'(0));
    chk("midrst_mem_req_rw",     128'(mem_req_rw),     128'(0));
    chk("midrst_mem_req_addr",   128'(mem_req_addr),   128'(0));
    chk("midrst_mem_req_wdata",  mem_req_wdata,        128'(0));
    pend = 1'b0; mem_stall = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_resp_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    chk("midrst_no_response", 128'(seen), 128'(0));
    model_reset();

    access(1'b0, 32'h300, 32'h0, rd, lat, nreq);
    model_step(1'b0, 32'h300, elat, ereq);
    chk("post_rst_rdata",   128'(rd),   128'(32'h03020100));
    chk("post_rst_latency", 128'(lat),  128'(4));
    chk("post_rst_memreqs", 128'(nreq), 128'(1));

    // Randomized traffic over 64 lines (4 aliases per index).
    for (int i = 0; i < 400; i++) begin
      bit rw;
      a  = 32'($urandom_range(0, 1023));
      rw = 1'($urandom_range(0, 1));
      wd = $urandom;
      exp_rd = rw ? wd : gword(a);
      access(rw, a, wd, rd, lat, nreq);
      model_step(rw, a, elat, ereq);
      if (rw) gold[a & ~32'h3] = wd;
      chk($sformatf("rnd%0d_rdata a=%0h", i, a), 128'(rd), 128'(exp_rd));
      chk($sformatf("rnd%0d_latency a=%0h", i, a), 128'(lat), 128'(elat));
      chk($sformatf("rnd%0d_memreqs a=%0h", i, a), 128'(nreq), 128'(ereq));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
